data_memory_controller: RTL and testbench
=========================================

DATA_MEMORY_CONTROLLER -- requirements
Module: data_memory_controller

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter MEMORY_DEPTH, default 256, number of words in the internal array.
REQ-003 SHALL have parameter WAIT_STATES, default 2, range 0..15, extra access cycles per transfer.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h1001_0000, byte address of word 0.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-007 req_i  input  1  access request; sampled only in IDLE.
REQ-008 we_i  input  1  1 = write, 0 = read; captured with req_i.
REQ-009 addr_i  input  32  byte address from the ALU result; captured with req_i.
REQ-010 wdata_i  input  DATA_WIDTH  store data (rt); captured with req_i.
REQ-011 ready_o  output  1  one-cycle completion pulse.
REQ-012 rdata_o  output  DATA_WIDTH  load data; valid while ready_o=1 and held afterward.
REQ-013 busy_o  output  1  high in every state except IDLE.
REQ-014 err_o  output  1  pulses with ready_o when the access is rejected.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, DONE; encoding is internal.
REQ-016 In IDLE with req_i=1, the block SHALL capture we_i, addr_i and wdata_i, load the wait counter with WAIT_STATES, and go to ACCESS, or go directly to DONE when WAIT_STATES=0.
REQ-017 In ACCESS the counter SHALL decrement once per cycle; on the cycle it reaches 0, the array access is performed and the state becomes DONE.
REQ-018 In DONE, ready_o SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; req_i is ignored in DONE.
REQ-019 Latency: ready_o SHALL rise exactly WAIT_STATES+1 cycles after the accept edge; back-to-back requests SHALL be accepted no sooner than the cycle after DONE.
REQ-020 Word index SHALL be (addr - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic with wrap-around.
REQ-021 An index >= MEMORY_DEPTH, including an address below BASE_ADDR, SHALL produce err_o=1 with ready_o; no write occurs and rdata_o keeps its previous value.
REQ-022 A write SHALL update exactly one word; rdata_o SHALL be unchanged by writes.
REQ-023 A read SHALL load rdata_o with the addressed word; the value holds until the next successful read.
REQ-024 Inputs changing during ACCESS or DONE SHALL have no effect on the transfer in flight.

Reset
REQ-025 reset=0 at a clock edge SHALL force IDLE, counter=0, ready_o=0, err_o=0, busy_o=0, rdata_o=0.
REQ-026 Reset asserted during ACCESS SHALL abort the transfer; a pending write SHALL NOT reach the array.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN defined: captured addr[1:0]!=0 SHALL give err_o=1 with ready_o, with no array access and rdata_o unchanged.
REQ-029 Macro DMEM_MISALIGN_TRAP_EN undefined: addr[1:0] SHALL be ignored and the access proceeds normally.

Structure
REQ-030 Package dmem_ctrl_pkg SHALL hold the FSM state typedef, the default BASE_ADDR and the WAIT_STATES upper bound.
REQ-031 The storage SHALL be a sub-module data_memory_array: single port, synchronous write, word-indexed.

Verification
REQ-032 Write 32'hDEADBEEF to 0x1001_0004, then read 0x1001_0004 -> ready_o 3 cycles after each accept; rdata_o=32'hDEADBEEF; err_o=0.
REQ-033 WAIT_STATES=0, read 0x1001_0000 -> ready_o on the cycle after the accept; busy_o high for exactly 1 cycle.
REQ-034 Read 0x1001_0400 (index 256), then read 0x1000_FFFC -> err_o=1 with ready_o in both cases; rdata_o unchanged.
REQ-035 Read address 0x1001_0002 -> err_o=1 with the macro defined; returns word 0 with err_o=0 with the macro undefined.
REQ-036 Write 32'h1234 to index 5, assert reset in the 1st ACCESS cycle, then read index 5 -> old contents returned; all outputs 0 during reset.
REQ-037 Hold req_i=1 continuously -> one ready_o pulse every WAIT_STATES+2 cycles; no request lost or duplicated.

Source files
------------

// File: rtl/data_memory_controller_pkg.sv
// Shared types and constants for the data memory controller.
// Holds the FSM state typedef, default base address and wait-state bound.
package dmem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } dmem_state_t;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
    localparam int unsigned WAIT_STATES_MAX   = 15;
    localparam int unsigned WAIT_CNT_W        = 4;

    // Word index relative to the base; wraps so addresses below the base land far out of range.
    function automatic logic [31:0] word_index(input logic [31:0] addr, input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return offset >> 2;
    endfunction

    function automatic int unsigned index_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_memory_controller_if.sv
// Request/response bus between a load/store unit and the data memory controller.
interface data_memory_controller_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_i;
    logic                  we_i;
    logic [31:0]           addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  busy_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, rdata_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, rdata_o, busy_o, err_o
    );
endinterface

// File: rtl/data_memory_controller_array.sv
// Single-port word array: synchronous write, combinational read at the same index.
module data_memory_array #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_DEPTH = 256,
    parameter int unsigned INDEX_W      = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [INDEX_W-1:0]    idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];
endmodule

// File: rtl/data_memory_controller.sv
// Wait-stated data memory controller (IDLE -> ACCESS -> DONE) around a word array.
// Optional macro DMEM_MISALIGN_TRAP_EN rejects accesses with addr[1:0] != 0.
module data_memory_controller
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEMORY_DEPTH = 256,
    parameter int unsigned WAIT_STATES  = 2,
    parameter logic [31:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
    input  logic clk,
    input  logic reset,
    data_memory_controller_if.slave bus
);
    localparam int unsigned             INDEX_W = index_width(MEMORY_DEPTH);
    localparam logic [WAIT_CNT_W-1:0]   WS      = WAIT_CNT_W'(WAIT_STATES);

    dmem_state_t           state;
    logic [WAIT_CNT_W-1:0] cnt;
    logic                  we_q;
    logic [31:0]           addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  ready_q;
    logic                  err_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic [31:0]           idx_full;
    logic                  ok;
    logic                  fire;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // With zero wait states the access happens on the accept edge, so the live inputs are used.
    always_comb begin
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_we    = bus.we_i;
            acc_addr  = bus.addr_i;
            acc_wdata = bus.wdata_i;
        end
        idx_full = word_index(acc_addr, BASE_ADDR);
        ok       = (idx_full < 32'(MEMORY_DEPTH));
`ifdef DMEM_MISALIGN_TRAP_EN
        ok       = ok && (acc_addr[1:0] == 2'b00);
`endif
        fire     = ((state == IDLE) && bus.req_i && (WS == '0)) ||
                   ((state == ACCESS) && (cnt == WAIT_CNT_W'(1)));
        mem_we   = reset && fire && acc_we && ok;
    end

    data_memory_array #(
        .DATA_WIDTH   (DATA_WIDTH),
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .INDEX_W      (INDEX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (idx_full[INDEX_W-1:0]),
        .wdata (acc_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_i) begin
                        we_q    <= bus.we_i;
                        addr_q  <= bus.addr_i;
                        wdata_q <= bus.wdata_i;
                        cnt     <= WS;
                        busy_q  <= 1'b1;
                        state   <= (WS == '0) ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - WAIT_CNT_W'(1);
                    if (cnt == WAIT_CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
            if (fire) begin
                ready_q <= 1'b1;
                err_q   <= !ok;
                if (ok && !acc_we) begin
                    rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.err_o   = err_q;
    assign bus.busy_o  = busy_q;
    assign bus.rdata_o = rdata_q;
endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench: default controller (2 wait states) plus a zero-wait-state instance.
module tb_data_memory_controller;
    import dmem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        we_s = 1'b0;
    logic [31:0] addr_s = '0;
    logic [31:0] wdata_s = '0;

    int n_checks = 0;
    int n_fail   = 0;

    data_memory_controller_if #(.DATA_WIDTH(32)) bus0 ();
    data_memory_controller_if #(.DATA_WIDTH(32)) bus1 ();

    assign bus0.req_i   = req0;
    assign bus0.we_i    = we_s;
    assign bus0.addr_i  = addr_s;
    assign bus0.wdata_i = wdata_s;
    assign bus1.req_i   = req1;
    assign bus1.we_i    = we_s;
    assign bus1.addr_i  = addr_s;
    assign bus1.wdata_i = wdata_s;

    data_memory_controller #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (256),
        .WAIT_STATES  (2),
        .BASE_ADDR    (32'h1001_0000)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.slave)
    );

    data_memory_controller #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (256),
        .WAIT_STATES  (0),
        .BASE_ADDR    (32'h1001_0000)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus0.ready_o : bus1.ready_o;
    endfunction

    function automatic logic bsy(input int sel);
        return (sel == 0) ? bus0.busy_o : bus1.busy_o;
    endfunction

    // Latency counts the accept cycle as 1; inputs are scrambled right after accept.
    task automatic do_access(input int sel, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, output int lat, output int busy_cyc,
                             output logic err, output logic [31:0] rdata, input string tag);
        @(negedge clk);
        we_s = we; addr_s = addr; wdata_s = wdata;
        if (sel == 0) req0 = 1'b1; else req1 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        we_s = ~we; addr_s = ~addr; wdata_s = ~wdata;
        lat = 1; busy_cyc = 0;
        while (!rdy(sel) && lat < 40) begin
            if (bsy(sel)) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (bsy(sel)) busy_cyc++;
        err   = (sel == 0) ? bus0.err_o : bus1.err_o;
        rdata = (sel == 0) ? bus0.rdata_o : bus1.rdata_o;
        @(posedge clk); #1;
        check_eq({tag, ".ready_width"}, 32'(rdy(sel)), 32'd0);
        if (bsy(sel)) busy_cyc++;
    endtask

    task automatic run_check(input int sel, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int exp_lat, input logic exp_err,
                             input logic [31:0] exp_rdata, input string tag);
        int          lat;
        int          busy_cyc;
        logic        err;
        logic [31:0] rdata;
        do_access(sel, we, addr, wdata, lat, busy_cyc, err, rdata, tag);
        check_eq({tag, ".lat"},   32'(lat),      32'(exp_lat));
        check_eq({tag, ".busy"},  32'(busy_cyc), 32'(exp_lat));
        check_eq({tag, ".err"},   32'(err),      32'(exp_err));
        check_eq({tag, ".rdata"}, rdata,         exp_rdata);
    endtask

    initial begin
        int          pulses;
        int          first;
        int          last;
        int          bad_gap;
        int          bad_data;
        logic [31:0] misalign_exp;
        logic        misalign_err;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.ready", 32'(bus0.ready_o), 32'd0);
        check_eq("rst.err",   32'(bus0.err_o),   32'd0);
        check_eq("rst.busy",  32'(bus0.busy_o),  32'd0);
        check_eq("rst.rdata", bus0.rdata_o,      32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_check(0, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 3, 1'b0, 32'h0000_0000, "wr_word1");
        run_check(0, 1'b0, 32'h1001_0004, 32'h0,         3, 1'b0, 32'hDEAD_BEEF, "rd_word1");

        run_check(1, 1'b1, 32'h1001_0000, 32'hA5A5_0001, 1, 1'b0, 32'h0000_0000, "ws0_wr");
        run_check(1, 1'b0, 32'h1001_0000, 32'h0,         1, 1'b0, 32'hA5A5_0001, "ws0_rd");

        run_check(0, 1'b1, 32'h1001_0000, 32'h1111_0000, 3, 1'b0, 32'hDEAD_BEEF, "wr_word0");
        run_check(0, 1'b1, 32'h1001_03FC, 32'h0000_00FF, 3, 1'b0, 32'hDEAD_BEEF, "wr_last");
        run_check(0, 1'b0, 32'h1001_0400, 32'h0,         3, 1'b1, 32'hDEAD_BEEF, "rd_idx256");
        run_check(0, 1'b0, 32'h1000_FFFC, 32'h0,         3, 1'b1, 32'hDEAD_BEEF, "rd_below");
        run_check(0, 1'b0, 32'h1001_03FC, 32'h0,         3, 1'b0, 32'h0000_00FF, "rd_last");
        run_check(0, 1'b1, 32'h1001_0400, 32'h5555_5555, 3, 1'b1, 32'h0000_00FF, "wr_idx256");

`ifdef DMEM_MISALIGN_TRAP_EN
        misalign_err = 1'b1;
        misalign_exp = 32'h0000_00FF;
`else
        misalign_err = 1'b0;
        misalign_exp = 32'h1111_0000;
`endif
        run_check(0, 1'b0, 32'h1001_0002, 32'h0, 3, misalign_err, misalign_exp, "rd_misalign");

        run_check(0, 1'b1, 32'h1001_0014, 32'h0000_AAAA, 3, 1'b0, misalign_exp, "wr_word5");

        @(negedge clk);
        we_s = 1'b1; addr_s = 32'h1001_0014; wdata_s = 32'h0000_1234; req0 = 1'b1;
        @(posedge clk); #1;
        req0 = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;
        check_eq("abort.ready", 32'(bus0.ready_o), 32'd0);
        check_eq("abort.err",   32'(bus0.err_o),   32'd0);
        check_eq("abort.busy",  32'(bus0.busy_o),  32'd0);
        check_eq("abort.rdata", bus0.rdata_o,      32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_check(0, 1'b0, 32'h1001_0014, 32'h0, 3, 1'b0, 32'h0000_AAAA, "rd_word5");

        @(negedge clk);
        we_s = 1'b0; addr_s = 32'h1001_0004; wdata_s = '0; req0 = 1'b1;
        pulses = 0; first = 0; last = 0; bad_gap = 0; bad_data = 0;
        for (int i = 1; i <= 24; i++) begin
            @(posedge clk); #1;
            if (bus0.ready_o) begin
                if (pulses == 0) first = i;
                else if (i - last != 4) bad_gap++;
                if (bus0.rdata_o !== 32'hDEAD_BEEF || bus0.err_o !== 1'b0) bad_data++;
                last = i;
                pulses++;
            end
        end
        req0 = 1'b0;
        check_eq("hold.pulses",  32'(pulses),   32'd6);
        check_eq("hold.first",   32'(first),    32'd3);
        check_eq("hold.bad_gap", 32'(bad_gap),  32'd0);
        check_eq("hold.data",    32'(bad_data), 32'd0);
        @(posedge clk); #1;
        check_eq("hold.idle", 32'(bus0.busy_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
